rs_alu: RTL and testbench

Reservation station and issue scheduler for the integer ALU. Buffers decoded ALU instructions whose source operands may still be pending, snoops the ALU and load/store result broadcasts to capture operands, and issues at most one ready instruction per cycle to the ALU. It sits between the decoder/dispatch stage and the ALU, and is flushed together with the ROB on misprediction.

---
 rtl/rs_alu.sv | 194 +++++++++++++++++++
 tb/tb_rs_alu.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// Integer ALU reservation station: buffers dispatched ops, snoops result broadcasts, issues one ready op per cycle.
// Optional macro RS_ALU_AGE_PRIORITY_EN selects oldest-first issue; otherwise the lowest-index ready entry issues.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 4
`endif

module rs_alu #(
    parameter int RS_SIZE_WIDTH        = 3,
    parameter int ROB_SIZE_WIDTH       = `ROB_SIZE_WIDTH,
    parameter int CALC_OP_L1_NUM_WIDTH = `CALC_OP_L1_NUM_WIDTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            dispatch_valid_in,
    input  logic [31:0]                     vj_in,
    input  logic [31:0]                     vk_in,
    input  logic [ROB_SIZE_WIDTH:0]         qj_in,
    input  logic [ROB_SIZE_WIDTH:0]         qk_in,
    input  logic [ROB_SIZE_WIDTH:0]         dest_in,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_in,
    input  logic                            alu_op_L2_in,
    input  logic                            alu_ready_in,
    input  logic [ROB_SIZE_WIDTH:0]         alu_dependency_in,
    input  logic [31:0]                     alu_value_in,
    input  logic                            lsb_ready_in,
    input  logic [ROB_SIZE_WIDTH:0]         lsb_dependency_in,
    input  logic [31:0]                     lsb_value_in,
    output logic                            valid_out,
    output logic [31:0]                     opr1_out,
    output logic [31:0]                     opr2_out,
    output logic [ROB_SIZE_WIDTH:0]         dependency_out,
    output logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
    output logic                            alu_op_L2_out,
    output logic                            full_out
);

    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    typedef logic [ROB_SIZE_WIDTH:0]  tag_t;
    typedef logic [RS_SIZE_WIDTH-1:0] idx_t;
    typedef logic [RS_SIZE_WIDTH:0]   cnt_t;

    typedef struct packed {
        tag_t        q;
        logic [31:0] v;
    } operand_t;

    localparam tag_t NO_TAG     = '1;
    localparam cnt_t FULL_COUNT = cnt_t'(RS_SIZE);

    logic [RS_SIZE-1:0]              busy;
    cnt_t                            count;
    operand_t                        opj     [RS_SIZE];
    operand_t                        opk     [RS_SIZE];
    tag_t                            dest    [RS_SIZE];
    logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1   [RS_SIZE];
    logic [RS_SIZE-1:0]              op_l2;

    logic [RS_SIZE-1:0] ready;
    logic               issue_fire;
    idx_t               issue_idx;
    logic               disp_fire;
    idx_t               disp_idx;

    // Resolve a pending operand against this cycle's broadcasts; the ALU result wins a tag tie.
    function automatic operand_t snoop(input operand_t o);
        operand_t r;
        r = o;
        if (o.q != NO_TAG) begin
            if (alu_ready_in && alu_dependency_in == o.q)
                r = '{q: NO_TAG, v: alu_value_in};
            else if (lsb_ready_in && lsb_dependency_in == o.q)
                r = '{q: NO_TAG, v: lsb_value_in};
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++)
            ready[i] = busy[i] && opj[i].q == NO_TAG && opk[i].q == NO_TAG;
    end

`ifdef RS_ALU_AGE_PRIORITY_EN
    // age[i] counts the busy entries dispatched before entry i, so the oldest has age 0.
    idx_t age [RS_SIZE];

    always_comb begin
        issue_fire = 1'b0;
        issue_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!issue_fire || age[i] < age[issue_idx])) begin
                issue_fire = 1'b1;
                issue_idx  = idx_t'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (rdy_in) begin
            if (need_flush_in) begin
                for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++)
                    if (issue_fire && busy[i] && age[i] > age[issue_idx])
                        age[i] <= age[i] - idx_t'(1);
                if (disp_fire)
                    age[disp_idx] <= idx_t'(count - cnt_t'(issue_fire));
            end
        end
    end
`else
    always_comb begin
        issue_fire = 1'b0;
        issue_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_fire = 1'b1;
                issue_idx  = idx_t'(i);
            end
        end
    end
`endif

    always_comb begin
        disp_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy[i]) disp_idx = idx_t'(i);
    end

    assign full_out  = (count == FULL_COUNT);
    assign disp_fire = dispatch_valid_in && !full_out;

    // NOTE: payload arrays carry no reset; busy alone decides whether their contents mean anything.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !need_flush_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    opj[i] <= snoop(opj[i]);
                    opk[i] <= snoop(opk[i]);
                end
            end
            if (disp_fire) begin
                opj[disp_idx]   <= snoop('{q: qj_in, v: vj_in});
                opk[disp_idx]   <= snoop('{q: qk_in, v: vk_in});
                dest[disp_idx]  <= dest_in;
                op_l1[disp_idx] <= alu_op_L1_in;
                op_l2[disp_idx] <= alu_op_L2_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy           <= '0;
            count          <= '0;
            valid_out      <= 1'b0;
            opr1_out       <= '0;
            opr2_out       <= '0;
            dependency_out <= NO_TAG;
            alu_op_L1_out  <= '0;
            alu_op_L2_out  <= 1'b0;
        end else if (rdy_in) begin
            if (need_flush_in) begin
                busy      <= '0;
                count     <= '0;
                valid_out <= 1'b0;
            end else begin
                valid_out <= issue_fire;
                if (issue_fire) begin
                    busy[issue_idx] <= 1'b0;
                    opr1_out        <= opj[issue_idx].v;
                    opr2_out        <= opk[issue_idx].v;
                    dependency_out  <= dest[issue_idx];
                    alu_op_L1_out   <= op_l1[issue_idx];
                    alu_op_L2_out   <= op_l2[issue_idx];
                end
                // The freed and the newly filled entry never coincide: dispatch only targets non-busy slots.
                if (disp_fire) busy[disp_idx] <= 1'b1;
                count <= count + cnt_t'(disp_fire) - cnt_t'(issue_fire);
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus random traffic against a slot/sequence-number reference model.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 4
`endif

module tb_rs_alu;

    localparam int TW = `ROB_SIZE_WIDTH + 1;
    localparam int LW = `CALC_OP_L1_NUM_WIDTH;
    localparam int N  = 8;
    localparam int BW = 1 + 32 + 32 + TW + LW + 1 + 1;
    localparam logic [TW-1:0] ONES = '1;
`ifdef RS_ALU_AGE_PRIORITY_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rdy, flush, d_valid, l2, a_rdy, l_rdy;
    logic [31:0] vj, vk, a_val, l_val;
    logic [TW-1:0] qj, qk, dest, a_tag, l_tag;
    logic [LW-1:0] l1;
    logic o_valid, o_l2, o_full;
    logic [31:0] o_opr1, o_opr2;
    logic [TW-1:0] o_dep;
    logic [LW-1:0] o_l1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rs_alu dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .need_flush_in(flush),
        .dispatch_valid_in(d_valid), .vj_in(vj), .vk_in(vk), .qj_in(qj), .qk_in(qk),
        .dest_in(dest), .alu_op_L1_in(l1), .alu_op_L2_in(l2),
        .alu_ready_in(a_rdy), .alu_dependency_in(a_tag), .alu_value_in(a_val),
        .lsb_ready_in(l_rdy), .lsb_dependency_in(l_tag), .lsb_value_in(l_val),
        .valid_out(o_valid), .opr1_out(o_opr1), .opr2_out(o_opr2), .dependency_out(o_dep),
        .alu_op_L1_out(o_l1), .alu_op_L2_out(o_l2), .full_out(o_full)
    );

    // Reference model: a table of slots; issue order by slot index or by global dispatch sequence.
    logic          m_busy [N];
    logic [31:0]   m_vj [N], m_vk [N];
    logic [TW-1:0] m_qj [N], m_qk [N], m_dest [N];
    logic [LW-1:0] m_l1 [N];
    logic          m_l2s [N];
    int            m_seq [N];
    int            seq_ctr = 0;
    logic          m_valid, m_ol2;
    logic [31:0]   m_opr1, m_opr2;
    logic [TW-1:0] m_dep;
    logic [LW-1:0] m_ol1;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [TW+31:0] snoop_m(input logic [TW-1:0] q, input logic [31:0] v);
        if (q == ONES) return {q, v};
        if (a_rdy && a_tag == q) return {ONES, a_val};
        if (l_rdy && l_tag == q) return {ONES, l_val};
        return {q, v};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {o_valid, o_opr1, o_opr2, o_dep, o_l1, o_l2, o_full};
    endfunction

    function automatic logic [BW-1:0] model_bundle();
        return {m_valid, m_opr1, m_opr2, m_dep, m_ol1, m_ol2, m_count() == N};
    endfunction

    task automatic model_step();
        int pick, slot, n;
        logic [TW+31:0] r;
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_valid = 1'b0; m_opr1 = '0; m_opr2 = '0; m_dep = ONES; m_ol1 = '0; m_ol2 = 1'b0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_valid = 1'b0;
            return;
        end
        n = m_count();
        pick = -1;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_qj[i] == ONES && m_qk[i] == ONES)
                if (pick < 0 || (AGE && m_seq[i] < m_seq[pick])) pick = i;
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                r = snoop_m(m_qj[i], m_vj[i]); m_qj[i] = r[TW+31:32]; m_vj[i] = r[31:0];
                r = snoop_m(m_qk[i], m_vk[i]); m_qk[i] = r[TW+31:32]; m_vk[i] = r[31:0];
            end
        end
        m_valid = (pick >= 0);
        if (pick >= 0) begin
            m_opr1 = m_vj[pick]; m_opr2 = m_vk[pick]; m_dep = m_dest[pick];
            m_ol1 = m_l1[pick]; m_ol2 = m_l2s[pick];
            m_busy[pick] = 1'b0;
        end
        if (d_valid && n < N) begin
            m_busy[slot] = 1'b1;
            r = snoop_m(qj, vj); m_qj[slot] = r[TW+31:32]; m_vj[slot] = r[31:0];
            r = snoop_m(qk, vk); m_qk[slot] = r[TW+31:32]; m_vk[slot] = r[31:0];
            m_dest[slot] = dest; m_l1[slot] = l1; m_l2s[slot] = l2;
            m_seq[slot] = seq_ctr;
            seq_ctr++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; d_valid = 1'b0;
        vj = '0; vk = '0; qj = ONES; qk = ONES; dest = '0; l1 = '0; l2 = 1'b0;
        a_rdy = 1'b0; a_tag = '0; a_val = '0; l_rdy = 1'b0; l_tag = '0; l_val = '0;
    endtask

    task automatic set_dispatch(input logic [31:0] j, input logic [31:0] k, input logic [TW-1:0] tj,
                                input logic [TW-1:0] tk, input logic [TW-1:0] d);
        d_valid = 1'b1; vj = j; vk = k; qj = tj; qk = tk; dest = d;
        l1 = LW'(d); l2 = d[0];
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (dut_bundle() !== {1'b0, 32'd0, 32'd0, ONES, {LW{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL reset_values: got %h want %h", dut_bundle(),
                     {1'b0, 32'd0, 32'd0, ONES, {LW{1'b0}}, 1'b0, 1'b0});
        end else n_pass++;
        // Reset mid-operation with rdy low still takes effect.
        set_dispatch(32'd1, 32'd2, ONES, ONES, 5'd9);
        tick(); tick();
        idle_inputs();
        rdy = 1'b0; rst = 1'b1;
        tick();
        n_total++;
        if (o_valid !== 1'b0 || o_full !== 1'b0 || o_dep !== ONES || o_opr1 !== 32'd0) begin
            $display("FAIL reset_mid_op: valid=%b full=%b dep=%h opr1=%h want 0 0 %h 0",
                     o_valid, o_full, o_dep, o_opr1, ONES);
        end else n_pass++;
        rst = 1'b0; rdy = 1'b1;
        tick();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL reset_clears_entries: valid=%b want 0", o_valid);
        else n_pass++;
    endtask

    task automatic test_ready_dispatch();
        do_reset();
        set_dispatch(32'd5, 32'd7, ONES, ONES, 5'd3);
        l1 = '0; l2 = 1'b0;
        tick();
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL ready_dispatch_n: valid=%b want 0", o_valid);
        else n_pass++;
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_opr2, o_dep} !== {1'b1, 32'd5, 32'd7, TW'(3)}) begin
            $display("FAIL ready_dispatch_issue: got v=%b %0d %0d dep=%0d want 1 5 7 3", o_valid, o_opr1, o_opr2, o_dep);
        end else n_pass++;
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_dep} !== {1'b0, 32'd5, TW'(3)}) begin
            $display("FAIL ready_dispatch_after: got v=%b opr1=%0d dep=%0d want 0 5 3 (held)", o_valid, o_opr1, o_dep);
        end else n_pass++;
    endtask

    task automatic test_wakeup();
        do_reset();
        set_dispatch(32'hDEAD, 32'd1, TW'(2), ONES, 5'd7);
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (o_valid !== 1'b0) $display("FAIL wakeup_hold_%0d: valid=%b want 0", c, o_valid);
            else n_pass++;
        end
        a_rdy = 1'b1; a_tag = TW'(2); a_val = 32'h10;
        tick();
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL wakeup_edge: valid=%b want 0", o_valid);
        else n_pass++;
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_opr2, o_dep} !== {1'b1, 32'h10, 32'd1, TW'(7)}) begin
            $display("FAIL wakeup_issue: got v=%b %h %h dep=%0d want 1 10 1 7", o_valid, o_opr1, o_opr2, o_dep);
        end else n_pass++;
    endtask

    task automatic test_forwarding();
        do_reset();
        set_dispatch(32'd9, 32'd0, ONES, TW'(4), 5'd8);
        l_rdy = 1'b1; l_tag = TW'(4); l_val = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_opr2} !== {1'b1, 32'd9, 32'hFFFF_FFFF}) begin
            $display("FAIL forward_lsb: got v=%b %h %h want 1 9 ffffffff", o_valid, o_opr1, o_opr2);
        end else n_pass++;
        // Both broadcasts carry the same tag: the ALU value is taken.
        set_dispatch(32'd0, 32'd3, TW'(5), ONES, 5'd11);
        a_rdy = 1'b1; a_tag = TW'(5); a_val = 32'hA;
        l_rdy = 1'b1; l_tag = TW'(5); l_val = 32'hB;
        tick();
        idle_inputs();
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_dep} !== {1'b1, 32'hA, TW'(11)}) begin
            $display("FAIL forward_alu_wins: got v=%b opr1=%h dep=%0d want 1 a 11", o_valid, o_opr1, o_dep);
        end else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_dispatch(32'(i), 32'(100 + i), TW'(6), ONES, TW'(i));
            tick();
        end
        idle_inputs();
        n_total++;
        if (o_full !== 1'b1) $display("FAIL full_set: full=%b want 1", o_full);
        else n_pass++;
        set_dispatch(32'd77, 32'd77, ONES, ONES, 5'd15);
        tick();
        idle_inputs();
        n_total++;
        if (o_full !== 1'b1 || o_valid !== 1'b0) begin
            $display("FAIL full_drop: full=%b valid=%b want 1 0", o_full, o_valid);
        end else n_pass++;
        a_rdy = 1'b1; a_tag = TW'(6); a_val = 32'h600;
        tick();
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            tick();
            n_total++;
            if ({o_valid, o_opr1, o_opr2, o_dep} !== {1'b1, 32'h600, 32'(100 + i), TW'(i)}) begin
                $display("FAIL full_drain_%0d: got v=%b %h %0d dep=%0d want 1 600 %0d %0d",
                         i, o_valid, o_opr1, o_opr2, o_dep, 100 + i, i);
            end else n_pass++;
        end
        tick();
        n_total++;
        if (o_full !== 1'b0 || o_valid !== 1'b0) begin
            $display("FAIL full_after_drain: full=%b valid=%b want 0 0 (dropped op must not issue)", o_full, o_valid);
        end else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_dispatch(32'(i), 32'(i), TW'(9), ONES, TW'(i));
            tick();
        end
        set_dispatch(32'd4, 32'd4, ONES, ONES, 5'd4);
        tick();
        set_dispatch(32'd5, 32'd5, ONES, ONES, 5'd5);
        flush = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (o_valid !== 1'b0 || o_full !== 1'b0) begin
            $display("FAIL flush_edge: valid=%b full=%b want 0 0", o_valid, o_full);
        end else n_pass++;
        a_rdy = 1'b1; a_tag = TW'(9); a_val = 32'h99;
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (o_valid !== 1'b0) $display("FAIL flush_empty_%0d: valid=%b want 0", c, o_valid);
            else n_pass++;
        end
    endtask

    task automatic test_issue_order();
        logic [TW-1:0] first, second;
        first  = AGE ? TW'(20) : TW'(21);
        second = AGE ? TW'(21) : TW'(20);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_dispatch(32'(i), 32'd0, (i == 1) ? TW'(11) : TW'(10), ONES, TW'(i));
            tick();
        end
        set_dispatch(32'd50, 32'd0, TW'(12), ONES, 5'd20);
        tick();
        idle_inputs();
        a_rdy = 1'b1; a_tag = TW'(11);
        tick();
        idle_inputs();
        tick();
        n_total++;
        if ({o_valid, o_dep} !== {1'b1, TW'(1)}) $display("FAIL order_free1: v=%b dep=%0d want 1 1", o_valid, o_dep);
        else n_pass++;
        set_dispatch(32'd10, 32'd0, TW'(12), ONES, 5'd21);
        tick();
        idle_inputs();
        l_rdy = 1'b1; l_tag = TW'(12); l_val = 32'hC;
        tick();
        idle_inputs();
        tick();
        n_total++;
        if ({o_valid, o_dep} !== {1'b1, first}) $display("FAIL order_first: v=%b dep=%0d want 1 %0d", o_valid, o_dep, first);
        else n_pass++;
        rdy = 1'b0;
        set_dispatch(32'd3, 32'd3, ONES, ONES, 5'd30);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if ({o_valid, o_opr1, o_dep, o_full} !== {1'b1, 32'hC, first, 1'b0}) begin
                $display("FAIL order_stall_%0d: v=%b opr1=%h dep=%0d full=%b want 1 c %0d 0", c, o_valid, o_opr1, o_dep, o_full, first);
            end else n_pass++;
        end
        idle_inputs();
        tick();
        n_total++;
        if ({o_valid, o_opr1, o_dep} !== {1'b1, 32'hC, second}) begin
            $display("FAIL order_second: v=%b opr1=%h dep=%0d want 1 c %0d", o_valid, o_opr1, o_dep, second);
        end else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            rst   = ($urandom_range(0, 199) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6) begin
                set_dispatch($urandom, $urandom,
                             ($urandom_range(0, 2) == 0) ? ONES : TW'($urandom_range(0, 3)),
                             ($urandom_range(0, 1) == 0) ? ONES : TW'($urandom_range(0, 3)),
                             TW'($urandom_range(0, 15)));
            end
            a_rdy = ($urandom_range(0, 2) == 0); a_tag = TW'($urandom_range(0, 3)); a_val = $urandom;
            l_rdy = ($urandom_range(0, 2) == 0); l_tag = TW'($urandom_range(0, 3)); l_val = $urandom;
            tick();
            n_total++;
            if (dut_bundle() !== model_bundle()) begin
                $display("FAIL random_cycle_%0d: got %h want %h", c, dut_bundle(), model_bundle());
            end else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_forwarding();
        test_full();
        test_flush();
        test_issue_order();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
